fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Serial transmit stage that drains the synchronous FIFO: pops one word at a time and shifts it out as an asynchronous serial frame.
- Frame format: start bit, data LSB first, optional parity bit, one stop bit.
- Sits directly downstream of the FIFO. It drives the FIFO read enable and consumes the FIFO's empty flag and read data.

Parameters:
- DATA_WIDTH, 8: FIFO word width and number of data bits per frame.
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be >= 1.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- enable  in  1  when high, the block may start a new frame.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_re is sampled high.
- fifo_re  out  1  FIFO read enable, registered, single-cycle pulse.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset: rst==0 at a rising edge gives the following state.
  - state=IDLE, tx=1, fifo_re=0, busy=0, frame_done=0.
  - Shift register, bit counter and baud counter are all cleared.
  - Reset has priority over every other event.
- Reset mid-frame: the frame is aborted immediately.
  - tx=1 from that edge.
  - No frame_done is issued and no pop is issued.
  - A word already popped but not yet sent is discarded.
- States: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- IDLE: at an edge where enable=1 and fifo_empty=0, set fifo_re<=1 and go to READ. Otherwise stay in IDLE.
- READ: fifo_re<=0; go to LOAD. The FIFO pops on this edge.
- LOAD: shreg<=fifo_data, tx<=0, baud_cnt<=0; go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shreg[0] and go to DATA.
- DATA: each bit is held for CLKS_PER_BIT cycles, LSB first. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP with tx<=1.
- PARITY: tx = XOR of the data bits, inverted when PARITY_ODD=1. Held for CLKS_PER_BIT cycles, then go to STOP with tx<=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. On the final edge, frame_done<=1 for one cycle and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary. Its width is clog2(CLKS_PER_BIT), minimum 1.
- Latency:
  - From the IDLE deciding edge E0: fifo_re is high during E0..E1, and tx falls at E2.
  - Frame length is (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles.
  - Back-to-back start-to-start spacing is frame length + 3 cycles.
- fifo_empty and enable are sampled only in IDLE.
- fifo_re is never high for two consecutive cycles.
- fifo_re is never asserted at an edge where fifo_empty was 1.
- enable deasserted mid-frame: the current frame completes normally and no new pop is issued.
- FIFO becoming empty mid-frame: no effect on the current frame; the block returns to IDLE and waits.
- tx is registered and glitch-free.

Test Plan:
- Reset with rst=0 for 2 cycles -> tx=1, fifo_re=0, busy=0, frame_done=0. FIFO empty afterwards -> the block stays idle.
- Default params, FIFO holding 0xA5, enable=1:
  - exactly one fifo_re pulse;
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total);
  - one frame_done at the end; busy high throughout.
- 16 words 0..15 written to the FIFO:
  - 16 fifo_re pulses;
  - the serialized bytes decode to 0..15 in order;
  - start-bit falling edges are 43 cycles apart;
  - ends idle with fifo_empty=1.
- PARITY_EN=1:
  - even parity, byte 0x07 -> parity bit 1;
  - odd parity, byte 0x07 -> parity bit 0;
  - each frame is 44 cycles.
- enable dropped during DATA of frame 1 with 3 words queued:
  - frame 1 completes;
  - no fifo_re while enable=0;
  - raising enable resumes with the next word.
- rst=0 asserted during data bit 3:
  - tx=1 and busy=0 after that edge;
  - no frame_done;
  - the next frame after release is clean and the aborted word is not resent.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial transmit stage: pops words from an upstream synchronous FIFO and
// shifts each one out as a frame of start bit, data LSB first, optional
// parity bit and one stop bit.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]      r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_par;
  logic                  r_tx;
  logic                  r_re;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  // Frame sequencer: FIFO handshake, bit timing and registered line drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (enable && !fifo_empty) begin
            r_re    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_re    <= 1'b0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shreg <= fifo_data;
          r_par   <= (^fifo_data) ^ ODD_SEL;
          r_tx    <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_tx    <= r_shreg[0];
              r_shreg <= r_shreg >> 1;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_re    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_re    = r_re;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
